// File: rtl/multi_tc.sv
`default_nettype none
// ============================================================================
// multi_tc : NCH independent WIDTH-bit down-counters, one-shot/auto-reload,
//            sticky W1C pending flags, per-channel and combined interrupts.
// Rev 1.0
// ============================================================================
module multi_tc #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    Addr,
  input  logic           WE,
  input  logic [31:0]    Din,
  output logic [31:0]    Dout,
  output logic [NCH-1:0] irq_vec,
  output logic           IRQ
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  logic [2:0]            ch_sel;
  logic [1:0]            reg_sel;
  logic [NCH-1:0][31:0]  ch_rdata;
  logic                  unused_bits;

  assign ch_sel      = Addr[6:4];
  assign reg_sel     = Addr[3:2];
  assign unused_bits = &{1'b0, Addr[31:7], Addr[1:0], Din};

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    state_t           state;
    logic             en;
    logic [1:0]       mode;
    logic             im;
    logic             pend;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             wr;
    logic [31:0]      rdata;

    // A channel index of NCH or more never matches, so such writes are dropped.
    assign wr = WE & (ch_sel == 3'(k));

    // A write to this channel freezes its FSM, COUNT and PEND for that cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= S_IDLE;
        en     <= 1'b0;
        mode   <= 2'b00;
        im     <= 1'b0;
        pend   <= 1'b0;
        preset <= '0;
        count  <= '0;
      end else if (wr) begin
        case (reg_sel)
          REG_CTRL: begin
            en   <= Din[0];
            mode <= Din[2:1];
            im   <= Din[3];
          end
          REG_PRESET: preset <= Din[WIDTH-1:0];
          REG_STATUS: if (Din[0]) pend <= 1'b0;
          default: ;
        endcase
      end else begin
        case (state)
          S_IDLE: begin
            if (en) state <= S_LOAD;
          end
          S_LOAD: begin
            count <= preset;
            state <= S_CNT;
          end
          S_CNT: begin
            if (!en) begin
              state <= S_IDLE;
            end else if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else begin
              count <= '0;
              pend  <= 1'b1;
              state <= S_INT;
            end
          end
          default: begin
            // MODE 1x is reserved and reloads like 01.
            if (mode == 2'b00) begin
              en    <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end
        endcase
      end
    end

    always_comb begin
      rdata = '0;
      case (reg_sel)
        REG_CTRL:   rdata = {28'd0, im, mode, en};
        REG_PRESET: rdata = 32'(preset);
        REG_COUNT:  rdata = 32'(count);
        default:    rdata = {31'd0, pend};
      endcase
    end

    assign ch_rdata[k] = rdata;
    assign irq_vec[k]  = pend & im;
  end

  always_comb begin
    Dout = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_sel == 3'(k)) Dout = ch_rdata[k];
    end
  end

  assign IRQ = |irq_vec;

endmodule
`default_nettype wire
